// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port synchronous VRAM between video scanout and a CPU bus.
// Latency: video data 2 cycles after vid_req; CPU write ack at issue+1, CPU read ack at issue+3.
// Backpressure: video always wins; CPU holds cpu_req until cpu_ack and may starve under continuous fetch.
// Build option: define VGA_VRAM_BLANK_ONLY_EN to let the CPU win only while bright==0.
module vga_vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              bright,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ACK  = 2'd1,
        RD_WAIT = 2'd2,
        RD_ACK  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   cpu_gate;
    logic   cpu_win;
    logic   rd_ack_q;
    logic   rdata_ld;
    logic   vid_p1;

`ifdef VGA_VRAM_BLANK_ONLY_EN
    // CPU restricted to blanking so the displayed frame never tears
    assign cpu_gate = ~bright;
`else
    logic unused_bright;
    assign unused_bright = bright;
    assign cpu_gate      = 1'b1;
`endif

    // CPU issues only from a quiet IDLE: not during the trailing read-ack cycle, never against video
    assign cpu_win = (state == IDLE) && !rd_ack_q && cpu_req && !vid_req && cpu_gate;

    // Video data comes straight from the RAM; vid_valid marks the cycle it belongs to the fetch
    assign vid_rdata = mem_rdata;

    // CPU FSM state register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CPU FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_win) state_nxt = cpu_we ? WR_ACK : RD_WAIT;
            WR_ACK:  state_nxt = IDLE;
            RD_WAIT: state_nxt = RD_ACK;
            RD_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // CPU FSM outputs: write ack decoded from state, read ack lags RD_ACK by one cycle
    always_comb begin
        rdata_ld = (state == RD_ACK);
        cpu_ack  = (state == WR_ACK) || rd_ack_q;
    end

    // Read-ack delay, CPU read-data capture and the two-stage video valid pipeline
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rd_ack_q  <= 1'b0;
            cpu_rdata <= '0;
            vid_p1    <= 1'b0;
            vid_valid <= 1'b0;
        end else begin
            rd_ack_q  <= rdata_ld;
            if (rdata_ld) begin
                cpu_rdata <= mem_rdata;
            end
            vid_p1    <= vid_req;
            vid_valid <= vid_p1;
        end
    end

    // VRAM port register: video first, then CPU; with no winner hold address/data and drop we
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (vid_req) begin
            mem_addr  <= vid_addr;
            mem_we    <= 1'b0;
        end else if (cpu_win) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_wdata;
        end else begin
            mem_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed table, corner sequences and random traffic for vga_vram_arbiter.
// A cycle-indexed expectation model plus a shadow memory predicts every output each cycle.
// The VRAM is a read-first synchronous RAM preloaded with addr+0x1000.
`timescale 1ns/1ps
module tb_vga_vram_arbiter;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXC = 4096;

    logic          sys_clk = 1'b0;
    logic          reset, bright, vid_req, cpu_req, cpu_we;
    logic [AW-1:0] vid_addr, cpu_addr, mem_addr;
    logic [DW-1:0] vid_rdata, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic          vid_valid, cpu_ack, mem_we;

    always #10 sys_clk = ~sys_clk;

    vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .bright    (bright),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_rdata (vid_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // VRAM model
    logic [DW-1:0] ram [65536];
    always @(posedge sys_clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state: expectations scheduled by absolute cycle number
    int            n_chk = 0, n_fail = 0, cyc = 0, live_from = -1, busy_until = -1;
    bit            e_vv [MAXC];
    bit            e_ack[MAXC];
    bit            e_we [MAXC];
    bit            rd_upd[MAXC];
    logic [DW-1:0] e_vd [MAXC];
    logic [DW-1:0] rd_val[MAXC];
    logic [DW-1:0] e_wd [MAXC];
    logic [AW-1:0] e_addr[MAXC];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rdata;
    logic [DW-1:0] shadow [65536];

    // Values observed in the most recent cycle
    logic          last_ack, last_we;
    logic [DW-1:0] last_rd;
    logic [AW-1:0] last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        if (live_from >= 0 && cyc > live_from) begin
            if (rd_upd[cyc]) m_rdata = rd_val[cyc];
            chk("vid_valid", 32'(vid_valid), 32'(e_vv[cyc]));
            if (e_vv[cyc]) chk("vid_rdata", 32'(vid_rdata), 32'(e_vd[cyc]));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_ack[cyc]));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
            chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
            if (e_we[cyc]) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
        end
    endtask

    // Apply the arbitration rules to this cycle's inputs and schedule what must follow
    task automatic model_step();
        int c = cyc;
        bit blank_ok;
`ifdef VGA_VRAM_BLANK_ONLY_EN
        blank_ok = !bright;
`else
        blank_ok = 1'b1;
`endif
        if (reset) begin
            for (int k = c + 1; k <= c + 3; k++) begin
                e_vv[k] = 1'b0; e_ack[k] = 1'b0; rd_upd[k] = 1'b0;
            end
            rd_upd[c+1] = 1'b1; rd_val[c+1] = '0;
            m_addr = '0; m_wd = '0;
            e_we[c+1] = 1'b0; e_addr[c+1] = '0; e_wd[c+1] = '0;
            busy_until = c;
            if (live_from < 0) live_from = c;
        end else if (vid_req) begin
            m_addr = vid_addr;
            e_we[c+1] = 1'b0; e_addr[c+1] = vid_addr; e_wd[c+1] = m_wd;
            e_vv[c+2] = 1'b1; e_vd[c+2] = shadow[vid_addr];
        end else if (cpu_req && blank_ok && c > busy_until) begin
            m_addr = cpu_addr; m_wd = cpu_wdata;
            e_we[c+1] = cpu_we; e_addr[c+1] = cpu_addr; e_wd[c+1] = cpu_wdata;
            if (cpu_we) begin
                shadow[cpu_addr] = cpu_wdata;
                e_ack[c+1] = 1'b1;
                busy_until = c + 1;
            end else begin
                e_ack[c+3] = 1'b1;
                rd_upd[c+3] = 1'b1; rd_val[c+3] = shadow[cpu_addr];
                busy_until = c + 3;
            end
        end else begin
            e_we[c+1] = 1'b0; e_addr[c+1] = m_addr; e_wd[c+1] = m_wd;
        end
    endtask

    // Called at the negedge of a cycle: check, advance model, move to the next cycle
    task automatic finish_cycle();
        model_check();
        model_step();
        last_ack = cpu_ack; last_we = mem_we; last_rd = cpu_rdata; last_addr = mem_addr;
        if (cyc >= MAXC - 4) begin
            $display("FAIL cycle_budget: cycle %0d exceeds limit %0d", cyc, MAXC - 4);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        @(negedge sys_clk);
        finish_cycle();
    endtask

    typedef struct {
        logic          vr;
        logic [15:0]   va;
        logic          cr;
        logic          cw;
        logic [15:0]   ca;
        logic [15:0]   cd;
        logic          x_vv;
        logic [15:0]   x_vd;
        logic          x_ack;
        logic [15:0]   x_rd;
        logic          x_we;
        logic [15:0]   x_addr;
        logic [15:0]   x_wd;
    } vec_t;

    function automatic vec_t mk(logic vr, logic [15:0] va, logic cr, logic cw, logic [15:0] ca,
                                logic [15:0] cd, logic vv, logic [15:0] vd, logic ack,
                                logic [15:0] rd, logic we, logic [15:0] ad, logic [15:0] wd);
        vec_t v;
        v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.x_vv = vv; v.x_vd = vd; v.x_ack = ack; v.x_rd = rd; v.x_we = we; v.x_addr = ad; v.x_wd = wd;
        return v;
    endfunction

    vec_t tbl [11];
    int   acks, ack_at, exp_at;
    bit   pend;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 16'(i + 16'h1000);
            shadow[i] = 16'(i + 16'h1000);
        end
        //            vr    va        cr    cw    ca        cd         vv    vd        ack   rd        we    addr      wd
        tbl[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[1]  = mk(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tbl[2]  = mk(1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0100, 16'h0000);
        tbl[3]  = mk(1'b1, 16'h0102, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1100, 1'b0, 16'h0000, 1'b0, 16'h0101, 16'h0000);
        tbl[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h1101, 1'b0, 16'h0000, 1'b0, 16'h0102, 16'h0000);
        tbl[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h1102, 1'b1, 16'h0000, 1'b1, 16'h0040, 16'hBEEF);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'hBEEF);
        tbl[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'h0000);
        tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0040, 16'h0000);
        tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0040, 16'h0000);
        tbl[10] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 16'h0040, 16'h0000);

        reset = 1'b1; bright = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(posedge sys_clk);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // Directed table: video burst, CPU write then read-back of the same word
        for (int r = 0; r < 11; r++) begin
            vid_req = tbl[r].vr; vid_addr = tbl[r].va;
            cpu_req = tbl[r].cr; cpu_we = tbl[r].cw; cpu_addr = tbl[r].ca; cpu_wdata = tbl[r].cd;
            @(negedge sys_clk);
            chk("tbl_vid_valid", 32'(vid_valid), 32'(tbl[r].x_vv));
            if (tbl[r].x_vv) chk("tbl_vid_rdata", 32'(vid_rdata), 32'(tbl[r].x_vd));
            chk("tbl_cpu_ack", 32'(cpu_ack), 32'(tbl[r].x_ack));
            chk("tbl_cpu_rdata", 32'(cpu_rdata), 32'(tbl[r].x_rd));
            chk("tbl_mem_we", 32'(mem_we), 32'(tbl[r].x_we));
            chk("tbl_mem_addr", 32'(mem_addr), 32'(tbl[r].x_addr));
            chk("tbl_mem_wdata", 32'(mem_wdata), 32'(tbl[r].x_wd));
            finish_cycle();
        end

        // CPU write held against 20 cycles of continuous video fetch
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0041; cpu_wdata = 16'h1234;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            vid_req = 1'b1; vid_addr = 16'(16'h0200 + i);
            tick();
            if (last_ack) acks++;
        end
        chk("starve_no_ack", 32'(acks), 32'd0);
        vid_req = 1'b0;
        tick();
        tick();
        chk("starve_ack", 32'(last_ack), 32'd1);
        chk("starve_mem_we", 32'(last_we), 32'd1);
        chk("starve_mem_addr", 32'(last_addr), 32'h0041);
        cpu_req = 1'b0;

        // CPU read while bright is high for 8 cycles, then blanking
        ack_at = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0041;
        for (int i = 0; i < 16; i++) begin
            bright = (i < 8);
            tick();
            if (last_ack && ack_at < 0) begin
                ack_at = i;
                cpu_req = 1'b0;
            end
        end
`ifdef VGA_VRAM_BLANK_ONLY_EN
        exp_at = 11;
`else
        exp_at = 3;
`endif
        chk("blank_ack_cycle", 32'(ack_at), 32'(exp_at));
        chk("blank_rdata", 32'(last_rd), 32'h1234);
        cpu_req = 1'b0; bright = 1'b0;

        // Reset while a read sits in RD_WAIT
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        tick();
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_ack) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        chk("rst_cpu_rdata", 32'(last_rd), 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 16'h5555;
        tick();
        tick();
        chk("rst_idle_write_ack", 32'(last_ack), 32'd1);
        cpu_req = 1'b0;

        // Random traffic against the model
        pend = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            vid_req  = 1'($urandom_range(0, 1));
            vid_addr = 16'($urandom_range(0, 31));
            bright   = 1'($urandom_range(0, 1));
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend      = 1'b1;
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 31));
                cpu_wdata = 16'($urandom);
            end
            tick();
            if (reset || last_ack) begin
                pend    = 1'b0;
                cpu_req = 1'b0;
            end
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
